// File: rtl/tank_button_if.sv
// tank_button_if: Avalon-MM slave bus between the interconnect and the button controller.
interface tank_button_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, read, write, writedata, input readdata);
  modport slave (input address, chipselect, read, write, writedata, output readdata);
endinterface

// File: rtl/tank_button_ctrl.sv
// tank_button_ctrl: synchronised, debounced push-buttons with edge capture and a maskable irq.
module tank_button_ctrl #(
  parameter int WIDTH = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             reset_n,
  tank_button_if.slave     bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync1_q, sync2_q, p_sync;
  logic [WIDTH-1:0] state_q, state_d, edge_cap_q, edge_cap_d, mask_q, mask_d, w1c;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] cfg_q, cfg_d;
  logic [31:0] readdata_q, readdata_d, rd_mux;
  logic wr, rd, unused_ok;
  assign p_sync = ~sync2_q;
  assign wr = bus.chipselect & bus.write;
  assign rd = bus.chipselect & bus.read;
  assign unused_ok = &{1'b0, bus.writedata};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (p_sync[i] == state_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] == TERM) begin
        state_d[i] = p_sync[i];
        cnt_d[i] = '0;
      end else cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end
  // A new event wins over a same-cycle write-1-to-clear of that bit.
  always_comb begin
    w1c = (wr && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : '0;
    edge_cap_d = (edge_cap_q & ~w1c)
               | (state_d & ~state_q & {WIDTH{cfg_q[0]}})
               | (~state_d & state_q & {WIDTH{cfg_q[1]}});
    mask_d = (wr && bus.address == 2'd1) ? bus.writedata[WIDTH-1:0] : mask_q;
    cfg_d = (wr && bus.address == 2'd3) ? bus.writedata[1:0] : cfg_q;
    rd_mux = (bus.address == 2'd0) ? 32'(state_q) :
             (bus.address == 2'd1) ? 32'(mask_q) :
             (bus.address == 2'd2) ? 32'(edge_cap_q) : {30'd0, cfg_q};
    readdata_d = rd ? rd_mux : readdata_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      state_q <= '0;
      cnt_q <= '0;
      edge_cap_q <= '0;
      mask_q <= '0;
      cfg_q <= 2'b01;
      readdata_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      edge_cap_q <= edge_cap_d;
      mask_q <= mask_d;
      cfg_q <= cfg_d;
      readdata_q <= readdata_d;
    end
  end
  assign bus.readdata = readdata_q;
  assign irq = |(edge_cap_q & mask_q);
endmodule

// File: tb/tb_tank_button_ctrl.sv
// tb_tank_button_ctrl: directed bus/pin sequence with DEBOUNCE_CYCLES=4; all signals driven and checked on negedge.
module tb_tank_button_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] in_port;
  logic irq;
  int vectors = 0;
  int miscompares = 0;
  tank_button_if bus ();
  tank_button_ctrl #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .in_port(in_port), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    bus.address = a; bus.chipselect = 1'b1; bus.read = 1'b1;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.read = 1'b0;
    check(tag, bus.readdata, exp);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write = 1'b1; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.writedata = '0;
  endtask
  initial begin
    reset_n = 1'b0; in_port = 2'b11;
    bus.address = '0; bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    wait_n(2);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_readdata", bus.readdata, 32'd0);
    reset_n = 1'b1;
    rd(2'd0, 32'd0, "rst_state");
    rd(2'd1, 32'd0, "rst_mask");
    rd(2'd2, 32'd0, "rst_edge");
    rd(2'd3, 32'd1, "rst_cfg");
    wait_n(1);
    check("readdata_hold", bus.readdata, 32'd1);
    // press bit0: state flips on the 6th edge after the pin change
    in_port[0] = 1'b0;
    wait_n(5);
    rd(2'd0, 32'd0, "press0_state_at5");
    rd(2'd0, 32'd1, "press0_state_at6");
    rd(2'd2, 32'd1, "press0_edge");
    check("press0_irq_masked", {31'd0, irq}, 32'd0);
    // bounce on bit1 never reaches terminal count
    in_port[1] = 1'b0; wait_n(3);
    in_port[1] = 1'b1; wait_n(1);
    in_port[1] = 1'b0; wait_n(3);
    in_port[1] = 1'b1; wait_n(10);
    rd(2'd0, 32'd1, "bounce_state");
    rd(2'd2, 32'd1, "bounce_edge");
    wr(2'd2, 32'd1);
    rd(2'd2, 32'd0, "w1c_edge");
    // mask both, release bit0 (not captured), then press it again
    wr(2'd1, 32'd3);
    rd(2'd1, 32'd3, "mask_rb");
    in_port[0] = 1'b1; wait_n(8);
    rd(2'd0, 32'd0, "release0_state");
    rd(2'd2, 32'd0, "release0_no_edge");
    in_port[0] = 1'b0;
    wait_n(5);
    check("irq_at5", {31'd0, irq}, 32'd0);
    wait_n(1);
    check("irq_at6", {31'd0, irq}, 32'd1);
    wr(2'd1, 32'd0);
    check("irq_mask_clear", {31'd0, irq}, 32'd0);
    rd(2'd2, 32'd1, "edge_retained");
    wr(2'd1, 32'd3);
    check("irq_mask_set", {31'd0, irq}, 32'd1);
    wr(2'd2, 32'd1);
    check("irq_after_w1c", {31'd0, irq}, 32'd0);
    rd(2'd2, 32'd0, "edge_after_w1c");
    // release-only capture, with W1C landing on the release edge
    wr(2'd3, 32'd2);
    rd(2'd3, 32'd2, "cfg_rb");
    in_port[1] = 1'b0; wait_n(8);
    rd(2'd0, 32'd3, "press1_state");
    rd(2'd2, 32'd0, "press1_not_captured");
    in_port[1] = 1'b1;
    wait_n(5);
    wr(2'd2, 32'd2);
    rd(2'd2, 32'd2, "set_wins_edge");
    check("set_wins_irq", {31'd0, irq}, 32'd1);
    rd(2'd0, 32'd1, "release1_state");
    wr(2'd2, 32'd2);
    rd(2'd2, 32'd0, "w1c_bit1");
    // reset mid-debounce with bit0 held pressed
    wr(2'd3, 32'd1);
    in_port[0] = 1'b1; wait_n(8);
    in_port[0] = 1'b0; wait_n(3);
    reset_n = 1'b0; wait_n(2);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_readdata", bus.readdata, 32'd0);
    reset_n = 1'b1;
    rd(2'd0, 32'd0, "midrst_state");
    rd(2'd1, 32'd0, "midrst_mask");
    rd(2'd2, 32'd0, "midrst_edge");
    rd(2'd3, 32'd1, "midrst_cfg");
    wait_n(1);
    rd(2'd0, 32'd0, "held_state_at5");
    rd(2'd0, 32'd1, "held_state_at6");
    rd(2'd2, 32'd1, "held_edge");
    check("held_irq_masked", {31'd0, irq}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
